// File: rtl/mem_dump_sequencer.sv
// rtl/mem_dump_sequencer.sv - walks data memory and streams each word MSB byte first to UART TX
module mem_dump_sequencer #(
  parameter int DATA_SIZE = 32,
  parameter int REG_SIZE  = 5,
  parameter int MEM_DEPTH = 32,
  parameter int BYTE_SIZE = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [DATA_SIZE-1:0] i_read_dm,
  input  logic                 i_tx_done,
  output logic                 o_debug_unit_flag,
  output logic                 o_memory_data_enable,
  output logic                 o_memory_data_read_enable,
  output logic [REG_SIZE-1:0]  o_memory_data_read_addr,
  output logic                 o_tx_start,
  output logic [BYTE_SIZE-1:0] o_tx_data,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int BYTES = DATA_SIZE / BYTE_SIZE;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [REG_SIZE-1:0] LAST_ADDR = REG_SIZE'(MEM_DEPTH - 1);
  localparam logic [CNT_W-1:0]    LAST_BYTE = CNT_W'(BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, READ_REQ, READ_WAIT, SEND, WAIT_TX, NEXT, DONE
  } state_t;

  state_t               state;
  logic [REG_SIZE-1:0]  addr;
  logic [CNT_W-1:0]     byte_cnt;
  logic [DATA_SIZE-1:0] word;
  logic [DATA_SIZE-1:0] word_shl;
  logic                 active;

  assign word_shl                = word << BYTE_SIZE;
  assign o_memory_data_read_addr = addr;
  assign o_busy                  = active;
  assign o_debug_unit_flag       = active;
  assign o_memory_data_enable    = active;

  // Every output is set on the transition into the state that owns it.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state                     <= IDLE;
      addr                      <= '0;
      byte_cnt                  <= '0;
      word                      <= '0;
      active                    <= 1'b0;
      o_memory_data_read_enable <= 1'b0;
      o_tx_start                <= 1'b0;
      o_tx_data                 <= '0;
      o_done                    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            addr                      <= '0;
            byte_cnt                  <= '0;
            active                    <= 1'b1;
            o_memory_data_read_enable <= 1'b1;
            state                     <= READ_REQ;
          end
        end
        READ_REQ: state <= READ_WAIT;
        READ_WAIT: begin
          word                      <= i_read_dm;
          o_tx_data                 <= i_read_dm[DATA_SIZE-1 -: BYTE_SIZE];
          o_tx_start                <= 1'b1;
          o_memory_data_read_enable <= 1'b0;
          state                     <= SEND;
        end
        SEND: begin
          o_tx_start <= 1'b0;
          state      <= WAIT_TX;
        end
        WAIT_TX: begin
          if (i_tx_done) begin
            word <= word_shl;
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= '0;
              state    <= NEXT;
            end else begin
              byte_cnt   <= byte_cnt + CNT_W'(1);
              o_tx_data  <= word_shl[DATA_SIZE-1 -: BYTE_SIZE];
              o_tx_start <= 1'b1;
              state      <= SEND;
            end
          end
        end
        NEXT: begin
          if (addr == LAST_ADDR) begin
            o_done <= 1'b1;
            state  <= DONE;
          end else begin
            addr                      <= addr + REG_SIZE'(1);
            o_memory_data_read_enable <= 1'b1;
            state                     <= READ_REQ;
          end
        end
        DONE: begin
          o_done    <= 1'b0;
          active    <= 1'b0;
          addr      <= '0;
          o_tx_data <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_sequencer.sv
// tb/tb_mem_dump_sequencer.sv - scoreboard bench for mem_dump_sequencer
module tb_mem_dump_sequencer;
  localparam int D = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        i_start = 1'b0, i_tx_done = 1'b0;
  logic [31:0] i_read_dm = 32'h0;
  logic        o_debug_unit_flag, o_memory_data_enable, o_memory_data_read_enable;
  logic [4:0]  o_memory_data_read_addr;
  logic        o_tx_start, o_busy, o_done;
  logic [7:0]  o_tx_data;

  mem_dump_sequencer #(.DATA_SIZE(32), .REG_SIZE(5), .MEM_DEPTH(D), .BYTE_SIZE(8)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(i_start), .i_read_dm(i_read_dm),
    .i_tx_done(i_tx_done), .o_debug_unit_flag(o_debug_unit_flag),
    .o_memory_data_enable(o_memory_data_enable),
    .o_memory_data_read_enable(o_memory_data_read_enable),
    .o_memory_data_read_addr(o_memory_data_read_addr), .o_tx_start(o_tx_start),
    .o_tx_data(o_tx_data), .o_busy(o_busy), .o_done(o_done));

  logic        s1_start = 1'b0, s1_tx_done = 1'b0;
  logic [31:0] s1_rd = 32'hDEADBEEF;
  logic        s1_flag, s1_en, s1_re, s1_tx_start, s1_busy, s1_done;
  logic [4:0]  s1_addr;
  logic [7:0]  s1_tx_data;

  mem_dump_sequencer #(.DATA_SIZE(32), .REG_SIZE(5), .MEM_DEPTH(1), .BYTE_SIZE(8)) dut1 (
    .i_clock(clk), .i_reset(rst), .i_start(s1_start), .i_read_dm(s1_rd),
    .i_tx_done(s1_tx_done), .o_debug_unit_flag(s1_flag), .o_memory_data_enable(s1_en),
    .o_memory_data_read_enable(s1_re), .o_memory_data_read_addr(s1_addr),
    .o_tx_start(s1_tx_start), .o_tx_data(s1_tx_data), .o_busy(s1_busy), .o_done(s1_done));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input bit ok, input string nm, input longint act, input longint want);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, want);
  endtask

  // Scoreboard: expected byte stream built from the memory pattern, plus per-cycle rules.
  int         cyc = 0, m_start_cyc = 0, re_cnt = 0, byte_no = 0, done_cnt = 0;
  bit         m_active = 0, waiting = 0, fast_mode = 0, exp_busy;
  logic [7:0] held, exb;
  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  logic       s_re = 0, s_re_prev = 0, s_tx_start = 0, s1_txs = 0;
  logic [4:0] s_addr = 0;
  logic [7:0] q1[$];
  int         d1_cnt = 0, d1_bytes = 0, d1_cyc = 0, s1_start_cyc = 0;

  always @(negedge clk) begin
    logic [31:0] w;
    cyc++;
    if (rst) begin
      m_active = 0;
      waiting  = 0;
      exp_q.delete();
    end else if (i_start && !m_active) begin
      m_active = 1; m_start_cyc = cyc; re_cnt = 0; byte_no = 0;
      for (int a = 0; a < D; a++) begin
        w = 32'h11223300 + a;
        for (int b = 0; b < 4; b++) exp_q.push_back(8'(w >> (8 * (3 - b))));
      end
    end
    exp_busy = m_active && (cyc > m_start_cyc);
    chk(o_busy == exp_busy, "busy", o_busy, exp_busy);
    chk(o_debug_unit_flag == exp_busy, "dbg_flag", o_debug_unit_flag, exp_busy);
    chk(o_memory_data_enable == exp_busy, "mem_en", o_memory_data_enable, exp_busy);
    if (!exp_busy) begin
      chk(!o_memory_data_read_enable && !o_tx_start && !o_done, "idle_strobes",
          {o_memory_data_read_enable, o_tx_start, o_done}, 0);
      chk(o_memory_data_read_addr == 0, "idle_addr", o_memory_data_read_addr, 0);
    end
    if (rst) chk(o_tx_data == 0, "reset_tx_data", o_tx_data, 0);
    if (o_memory_data_read_enable) begin
      re_cnt++;
      chk(!waiting && !o_tx_start, "re_window", {waiting, o_tx_start}, 0);
    end
    if (o_tx_start) begin
      if (exp_q.size() == 0) chk(0, "tx_start_unexpected", o_tx_data, 0);
      else begin
        exb = exp_q.pop_front();
        chk(o_tx_data == exb, "tx_byte", o_tx_data, exb);
        chk(o_memory_data_read_addr == 5'(byte_no / 4), "tx_addr", o_memory_data_read_addr, byte_no / 4);
        byte_no++;
      end
      waiting = 1; held = o_tx_data;
      got.push_back(o_tx_data);
    end else if (waiting) begin
      chk(o_tx_data == held, "tx_data_hold", o_tx_data, held);
      if (i_tx_done) waiting = 0;
    end
    if (o_done) begin
      done_cnt++;
      chk(m_active && exp_q.size() == 0 && !waiting, "done_early", exp_q.size(), 0);
      chk(re_cnt == 2 * D, "re_cycles", re_cnt, 2 * D);
      if (fast_mode) chk(cyc - m_start_cyc == 353, "done_latency", cyc - m_start_cyc, 353);
      m_active = 0;
    end
    s_re_prev = s_re; s_re = o_memory_data_read_enable;
    s_addr = o_memory_data_read_addr; s_tx_start = o_tx_start;
    s1_txs = s1_tx_start;
    if (s1_start) s1_start_cyc = cyc;
    if (s1_tx_start) q1.push_back(s1_tx_data);
    if (s1_done) begin d1_cnt++; d1_bytes = q1.size(); d1_cyc = cyc; end
  end

  int delay = 1, txd_cnt = 0;
  bit spurious = 0;

  // Memory answers one cycle after a read strobe; UART returns tx_done `delay` cycles after tx_start.
  task automatic step();
    @(posedge clk); #1;
    i_start = 0; i_tx_done = 0; s1_start = 0; s1_tx_done = 0;
    i_read_dm = s_re ? 32'h11223300 + {27'd0, s_addr} : 32'hBAD0BAD0;
    if (s_tx_start) txd_cnt = delay;
    if (txd_cnt > 0) begin
      txd_cnt--;
      if (txd_cnt == 0) i_tx_done = 1;
    end
    if (spurious && s_re && !s_re_prev) i_tx_done = 1;
    if (s1_txs) s1_tx_done = 1;
  endtask

  task automatic run_to_done(input int budget, input string nm);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin step(); n++; end
    chk(done_cnt != d0, nm, n, budget);
  endtask

  initial begin
    bit pulsed;
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (10) step();
    chk(got.size() == 0, "idle_no_tx", got.size(), 0);

    // Fast echo; a start coinciding with DONE must be ignored.
    got.delete(); done_cnt = 0; delay = 1; fast_mode = 1;
    step(); i_start = 1;
    repeat (353) step();
    chk(o_done == 1, "done_at_353", o_done, 1);
    i_start = 1;
    repeat (6) step();
    chk(o_busy == 0, "start_on_done_ignored", o_busy, 0);
    chk(done_cnt == 1, "done_once", done_cnt, 1);
    chk(got.size() == 128, "byte_count", got.size(), 128);
    chk(got.size() == 128 && got[0] == 8'h11 && got[3] == 8'h00 && got[7] == 8'h01,
        "first_words", got.size() > 7 ? {got[0], got[3], got[7]} : 0, 24'h110001);
    chk(got.size() == 128 && got[124] == 8'h11 && got[127] == 8'h1F, "last_word",
        got.size() == 128 ? {got[124], got[127]} : 0, 16'h111F);

    // Slow UART plus spurious tx_done in READ_WAIT.
    got.delete(); done_cnt = 0; delay = 20; spurious = 1; fast_mode = 0;
    step(); i_start = 1;
    run_to_done(6000, "slow_dump_timeout");
    chk(got.size() == 128, "slow_byte_count", got.size(), 128);
    chk(got.size() == 128 && got[5] == 8'h22 && got[127] == 8'h1F, "slow_bytes",
        got.size() == 128 ? {got[5], got[127]} : 0, 16'h221F);
    spurious = 0;

    // Second start at word 5 is ignored.
    got.delete(); done_cnt = 0; delay = 1; fast_mode = 1; pulsed = 0;
    step(); i_start = 1;
    n = 0;
    while (done_cnt == 0 && n < 1000) begin
      step(); n++;
      if (!pulsed && o_busy && s_addr == 5) begin i_start = 1; pulsed = 1; end
    end
    chk(done_cnt == 1 && pulsed, "mid_start_done", done_cnt, 1);
    repeat (10) step();
    chk(done_cnt == 1, "mid_start_single_done", done_cnt, 1);
    chk(got.size() == 128, "mid_start_bytes", got.size(), 128);

    // Asynchronous reset while waiting on word 7.
    got.delete(); done_cnt = 0; delay = 20; fast_mode = 0;
    step(); i_start = 1;
    n = 0;
    while (!(s_tx_start && s_addr == 7) && n < 3000) begin step(); n++; end
    chk(n < 3000, "reach_word7", n, 3000);
    step();
    #2 rst = 1;
    #1;
    chk({o_busy, o_debug_unit_flag, o_memory_data_enable, o_memory_data_read_enable,
         o_tx_start, o_done} == 0, "reset_strobes",
        {o_busy, o_debug_unit_flag, o_memory_data_enable, o_memory_data_read_enable, o_tx_start, o_done}, 0);
    chk(o_memory_data_read_addr == 0 && o_tx_data == 0, "reset_data",
        {o_memory_data_read_addr, o_tx_data}, 0);
    txd_cnt = 0;
    @(posedge clk); #1 rst = 0;
    got.delete(); done_cnt = 0;
    repeat (5) step();
    chk(got.size() == 0, "no_tx_after_reset", got.size(), 0);
    delay = 1; fast_mode = 1;
    step(); i_start = 1;
    run_to_done(1000, "restart_timeout");
    chk(got.size() == 128 && got[0] == 8'h11 && got[3] == 8'h00, "restart_addr0",
        got.size(), 128);

    // MEM_DEPTH=1 instance.
    q1.delete(); d1_cnt = 0;
    step(); s1_start = 1;
    repeat (30) step();
    chk(q1.size() == 4, "d1_byte_count", q1.size(), 4);
    chk(q1.size() == 4 && {q1[0], q1[1], q1[2], q1[3]} == 32'hDEADBEEF, "d1_bytes",
        q1.size() == 4 ? {q1[0], q1[1], q1[2], q1[3]} : 0, 32'hDEADBEEF);
    chk(d1_cnt == 1 && d1_bytes == 4, "d1_done_after_bytes", {d1_cnt, d1_bytes}, {32'd1, 32'd4});
    chk(d1_cyc - s1_start_cyc == 12, "d1_done_latency", d1_cyc - s1_start_cyc, 12);
    chk(!s1_busy && !s1_re && !s1_flag, "d1_idle", {s1_busy, s1_re, s1_flag}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
